// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seq_state_t;

  localparam int EVENT_CNT_W = 16;

  // Counter width for a count range of n; never narrower than one bit.
  function automatic int cnt_width(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_req_sync.sv
// Async-clear synchroniser for one active-low reset request. The request
// itself clears the chain, so assertion is immediate and release is synchronous.
module reset_req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_req_n,
  output logic o_req_n
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   clr_n;

  assign clr_n = i_rstn & i_req_n;

  // Shift ones in once both the master reset and the request are released.
  always_ff @(posedge i_clk or negedge clr_n) begin
    if (!clr_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign o_req_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Master reset sequencer: merges primary, requested and software resets,
// enforces a minimum assertion width and releases the outputs in order,
// one STAGE_DELAY apart, each through an RST_PIPE_LENGTH fanout pipeline.
// Optional feature: define RESET_SEQ_EVENT_CNT_EN to add o_event_cnt, a
// saturating count of re-entries into HOLD from RELEASE or DONE.
//
// state   | meaning
// HOLD    | all outputs held in reset, counting the minimum assertion width
// RELEASE | outputs being released one per STAGE_DELAY cycles
// DONE    | every output released; waits for a new reset request
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_INPUT_RESETS  = 1,
  parameter int NUM_OUTPUT_RESETS = 4,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int STAGE_DELAY       = 8,
  parameter int SYNC_STAGES       = 2,
  parameter int RST_PIPE_LENGTH   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [NUM_INPUT_RESETS-1:0]  i_rstn_array,
  input  logic                         i_sw_rst_req,
  output logic [NUM_OUTPUT_RESETS-1:0] o_rstn_array,
  output logic                         o_reset_done,
`ifdef RESET_SEQ_EVENT_CNT_EN
  output logic [EVENT_CNT_W-1:0]       o_event_cnt,
`endif
  output logic [1:0]                   o_seq_state
);

  localparam int HOLD_W  = cnt_width(MIN_ASSERT_CYCLES);
  localparam int STAGE_W = cnt_width(STAGE_DELAY);

  logic [NUM_INPUT_RESETS-1:0]  synced;
  logic                         req_n;
  logic                         restart;
  seq_state_t                   state_q;
  logic [HOLD_W-1:0]            hold_cnt_q;
  logic [STAGE_W-1:0]           stage_cnt_q;
  logic [NUM_OUTPUT_RESETS-1:0] rel_vec_q;
  logic [NUM_OUTPUT_RESETS-1:0] rel_first_d;
  logic [NUM_OUTPUT_RESETS-1:0] rel_next_d;
  logic [NUM_OUTPUT_RESETS-1:0] pipe_q [RST_PIPE_LENGTH];
  logic                         done_q;

  for (genvar g = 0; g < NUM_INPUT_RESETS; g++) begin : g_sync
    reset_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_req_n (i_rstn_array[g]),
      .o_req_n (synced[g])
    );
  end

  assign req_n   = &synced;
  assign restart = ~req_n | i_sw_rst_req;

  // Release vector is a thermometer from bit 0; the next stage is one shift up.
  always_comb begin
    rel_first_d    = '0;
    rel_first_d[0] = 1'b1;
    rel_next_d     = rel_vec_q | (rel_vec_q << 1);
  end

  // Sequencer FSM, counters, release vector and output pipelines.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      stage_cnt_q <= '0;
      rel_vec_q   <= '0;
      done_q      <= 1'b0;
      for (int s = 0; s < RST_PIPE_LENGTH; s++) pipe_q[s] <= '0;
    end else if (restart) begin
      // Assertion bypasses the pipeline so every output drops together.
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      stage_cnt_q <= '0;
      rel_vec_q   <= '0;
      done_q      <= 1'b0;
      for (int s = 0; s < RST_PIPE_LENGTH; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= rel_vec_q;
      for (int s = 1; s < RST_PIPE_LENGTH; s++) pipe_q[s] <= pipe_q[s-1];
      done_q <= pipe_q[RST_PIPE_LENGTH-1][NUM_OUTPUT_RESETS-1];
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == HOLD_W'(MIN_ASSERT_CYCLES - 1)) begin
            hold_cnt_q <= '0;
            rel_vec_q  <= rel_first_d;
            state_q    <= (NUM_OUTPUT_RESETS == 1) ? DONE : RELEASE;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        RELEASE: begin
          if (stage_cnt_q == STAGE_W'(STAGE_DELAY - 1)) begin
            stage_cnt_q <= '0;
            rel_vec_q   <= rel_next_d;
            if (rel_next_d[NUM_OUTPUT_RESETS-1]) state_q <= DONE;
          end else begin
            stage_cnt_q <= stage_cnt_q + STAGE_W'(1);
          end
        end
        DONE: ;
        default: state_q <= HOLD;
      endcase
    end
  end

`ifdef RESET_SEQ_EVENT_CNT_EN
  logic [EVENT_CNT_W-1:0] event_cnt_q;

  // Count re-entries into HOLD from an active sequence; saturates at all-ones.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      event_cnt_q <= '0;
    end else if (restart && (state_q == RELEASE || state_q == DONE) &&
                 (event_cnt_q != {EVENT_CNT_W{1'b1}})) begin
      event_cnt_q <= event_cnt_q + EVENT_CNT_W'(1);
    end
  end

  assign o_event_cnt = event_cnt_q;
`endif

  assign o_rstn_array = pipe_q[RST_PIPE_LENGTH-1];
  assign o_reset_done = done_q;
  assign o_seq_state  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance driven from a scenario table,
// plus a minimum-parameter instance and the optional event counter.
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int MIN  = 16;
  localparam int SD   = 8;
  localparam int SYNC = 2;
  localparam int PIPE = 2;
  localparam int BASE_RST = SYNC + MIN + PIPE;
  localparam int BASE_SW  = MIN + PIPE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, sw;
  logic [0:0]   arr;
  logic [N-1:0] o;
  logic         done;
  logic [1:0]   st;

  logic         rstn_e, sw_e;
  logic [0:0]   arr_e;
  logic [0:0]   o_e;
  logic         done_e;
  logic [1:0]   st_e;

`ifdef RESET_SEQ_EVENT_CNT_EN
  logic [15:0] evt, evt_e;
`endif

  reset_sequencer dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_rstn_array (arr),
    .i_sw_rst_req (sw),
    .o_rstn_array (o),
    .o_reset_done (done),
`ifdef RESET_SEQ_EVENT_CNT_EN
    .o_event_cnt  (evt),
`endif
    .o_seq_state  (st)
  );

  reset_sequencer #(
    .NUM_OUTPUT_RESETS (1),
    .MIN_ASSERT_CYCLES (1),
    .STAGE_DELAY       (1),
    .RST_PIPE_LENGTH   (1)
  ) dut_e (
    .i_clk        (clk),
    .i_rstn       (rstn_e),
    .i_rstn_array (arr_e),
    .i_sw_rst_req (sw_e),
    .o_rstn_array (o_e),
    .o_reset_done (done_e),
`ifdef RESET_SEQ_EVENT_CNT_EN
    .o_event_cnt  (evt_e),
`endif
    .o_seq_state  (st_e)
  );

  typedef struct {
    int           e;
    logic [N-1:0] o;
    logic         done;
    logic [1:0]   st;
  } exp_t;

  typedef enum {A_NONE, A_RSTN, A_ARR, A_SW} act_t;

  typedef struct {
    act_t act;
    int   wait_n;
    int   len;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   seq_e    = 0;
  int   seq_b    = 1000;

  // Expected outputs e edges into a sequence whose first output rises at edge b.
  function automatic exp_t model(int e, int b, int n, int sd, int pipe);
    exp_t x;
    int   r0;
    x.e = e;
    x.o = '0;
    for (int k = 0; k < n; k++) x.o[k] = (e >= b + k * sd);
    x.done = (e >= b + (n - 1) * sd + 1);
    r0 = b - pipe;
    if (e < r0)                      x.st = 2'd0;
    else if (e < r0 + (n - 1) * sd)  x.st = 2'd1;
    else                             x.st = 2'd2;
    return x;
  endfunction

  function automatic exp_t zero_exp();
    return model(-1, 1000, N, SD, PIPE);
  endfunction

  task automatic compare(string nm, exp_t x, logic [N-1:0] ao, logic ad, logic [1:0] ast);
    checks++;
    if (ao !== x.o || ad !== x.done || ast !== x.st) begin
      failures++;
      $display("FAIL %s e=%0d got o=%b done=%b st=%0d required o=%b done=%b st=%0d",
               nm, x.e, ao, ad, ast, x.o, x.done, x.st);
    end
  endtask

  task automatic pop_cmp(bit sel, string nm);
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty got nothing required one entry", nm);
      return;
    end
    x = sb.pop_front();
    if (sel) compare(nm, x, {{(N-1){1'b0}}, o_e}, done_e, st_e);
    else     compare(nm, x, o, done, st);
  endtask

  // Push the expectation, advance one edge, sample 1 unit later, compare.
  task automatic tick(bit sel, exp_t x, string nm);
    sb.push_back(x);
    @(posedge clk);
    #1;
    pop_cmp(sel, nm);
  endtask

  task automatic run_main(int n);
    for (int i = 0; i < n; i++) begin
      seq_e++;
      tick(1'b0, model(seq_e, seq_b, N, SD, PIPE), "seq");
    end
  endtask

  task automatic do_rstn(int len);
    rstn = 1'b0;
    #1;
    sb.push_back(zero_exp());
    pop_cmp(1'b0, "rstn_async");
    for (int i = 0; i < len; i++) tick(1'b0, zero_exp(), "rstn_low");
    rstn  = 1'b1;
    seq_e = 0;
    seq_b = BASE_RST;
  endtask

  task automatic do_arr(int len);
    arr = 1'b0;
    for (int i = 0; i < len; i++) tick(1'b0, zero_exp(), "req_low");
    arr   = 1'b1;
    seq_e = 0;
    seq_b = BASE_RST;
  endtask

  task automatic do_sw();
    sw = 1'b1;
    tick(1'b0, zero_exp(), "sw_edge");
    sw    = 1'b0;
    seq_e = 0;
    seq_b = BASE_SW;
  endtask

  task automatic check_val(string nm, logic [15:0] got, logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %h required %h", nm, got, want);
    end
  endtask

  vec_t vecs[8];

  initial begin
    // wait_n: edges run in the current sequence before the action.
    vecs[0] = '{A_RSTN, 0,  5};  // release order from power-up
    vecs[1] = '{A_SW,   50, 1};  // software reset in DONE
    vecs[2] = '{A_RSTN, 28, 3};  // primary reset after output 1 released
    vecs[3] = '{A_ARR,  10, 3};  // request during HOLD restarts the count
    vecs[4] = '{A_SW,   17, 1};  // pulse on the HOLD exit edge wins
    vecs[5] = '{A_SW,   39, 1};  // pulse on the final RELEASE edge wins
    vecs[6] = '{A_ARR,  45, 2};  // request in DONE
    vecs[7] = '{A_NONE, 50, 0};

    rstn   = 1'b1;
    rstn_e = 1'b1;
    arr    = 1'b1;
    arr_e  = 1'b1;
    sw     = 1'b0;
    sw_e   = 1'b0;
    #2;
    rstn   = 1'b0;
    rstn_e = 1'b0;
    #1;
    sb.push_back(zero_exp());
    pop_cmp(1'b0, "reset_state");
    sb.push_back(zero_exp());
    pop_cmp(1'b1, "reset_state_e");
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      run_main(vecs[v].wait_n);
      case (vecs[v].act)
        A_RSTN: do_rstn(vecs[v].len);
        A_ARR:  do_arr(vecs[v].len);
        A_SW:   do_sw();
        default: ;
      endcase
    end

    // Minimum parameters: rise at edge 4, done at edge 5.
    rstn_e = 1'b1;
    for (int e = 1; e <= 8; e++) tick(1'b1, model(e, 4, 1, 1, 1), "edge_par");
    sw_e = 1'b1;
    tick(1'b1, zero_exp(), "edge_par_sw");
    sw_e = 1'b0;
    for (int e = 1; e <= 5; e++) tick(1'b1, model(e, 2, 1, 1, 1), "edge_par_sw_seq");

`ifdef RESET_SEQ_EVENT_CNT_EN
    check_val("evt_e", evt_e, 16'd1);
    do_rstn(2);
    check_val("evt_clear", evt, 16'd0);
    run_main(50);
    for (int p = 0; p < 3; p++) begin
      do_sw();
      run_main(50);
    end
    check_val("evt_three", evt, 16'd3);
    force dut.event_cnt_q = 16'hFFFF;
    @(posedge clk);
    release dut.event_cnt_q;
    #1;
    check_val("evt_forced", evt, 16'hFFFF);
    do_sw();
    run_main(5);
    check_val("evt_saturate", evt, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
